// File: rtl/uart_8250_pkg.sv
// Shared definitions for the 8250-compatible UART: LCR bit positions, TX FSM
// state codes, register offsets, and small LCR decode helpers.
package uart_8250_pkg;

  localparam int LCR_WLS_LSB = 0;
  localparam int LCR_STB     = 2;
  localparam int LCR_PEN     = 3;
  localparam int LCR_EPS     = 4;
  localparam int LCR_SP      = 5;
  localparam int LCR_BC      = 6;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam logic [2:0] REG_RBR_THR = 3'd0;
  localparam logic [2:0] REG_IER     = 3'd1;
  localparam logic [2:0] REG_IIR_FCR = 3'd2;
  localparam logic [2:0] REG_LCR     = 3'd3;
  localparam logic [2:0] REG_MCR     = 3'd4;
  localparam logic [2:0] REG_LSR     = 3'd5;
  localparam logic [2:0] REG_MSR     = 3'd6;
  localparam logic [2:0] REG_SCR     = 3'd7;

  // 1.5 stop bits only exist for 5-bit characters; otherwise STB selects 2.
  function automatic logic [5:0] stopTicks(input logic [5:0] lcrBits);
    if (!lcrBits[LCR_STB])          return 6'd16;
    else if (lcrBits[1:0] == 2'b00) return 6'd24;
    else                            return 6'd32;
  endfunction

  function automatic logic dataParity(input logic [7:0] data, input logic [1:0] wls);
    logic [7:0] mask;
    mask = 8'hFF >> (2'd3 - wls);
    return ^(data & mask);
  endfunction

endpackage

// File: rtl/uart_8250_baudgen.sv
// Divisor prescaler plus 16x tick counter; bit_end fires on the last tick of
// a bit whose length (in ticks) is supplied by the transmitter.
module uart_8250_baudgen #(
  parameter int CLK_DIV_W = 16
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic                 i_restart,
  input  logic [CLK_DIV_W-1:0] i_divisor,
  input  logic [5:0]           i_bit_ticks,
  output logic                 o_tick,
  output logic                 o_bit_end
);

  logic [CLK_DIV_W-1:0] r_pre;
  logic [CLK_DIV_W-1:0] r_div;
  logic [5:0]           r_tick;

  assign o_tick    = (r_div != '0) && (r_pre == r_div - CLK_DIV_W'(1));
  assign o_bit_end = o_tick && (r_tick == i_bit_ticks - 6'd1);

  // The divisor is sampled only on reload, so a zero divisor parks everything.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_pre  <= '0;
      r_div  <= '0;
      r_tick <= '0;
    end else if (i_restart) begin
      r_pre  <= '0;
      r_div  <= i_divisor;
      r_tick <= '0;
    end else if (r_div == '0) begin
      r_div <= i_divisor;
    end else if (o_tick) begin
      r_pre  <= '0;
      r_div  <= i_divisor;
      r_tick <= o_bit_end ? 6'd0 : r_tick + 6'd1;
    end else begin
      r_pre <= r_pre + CLK_DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_8250_tx.sv
// 8250 transmit serialiser: THR holding register, shift register with a
// per-character LCR snapshot, and the START/DATA/PARITY/STOP sequencer.
module uart_8250_tx #(
  parameter int CLK_DIV_W = 16
) (
  input  logic                 CLK_I,
  input  logic                 RST_I,
  input  logic [7:0]           thr_data,
  input  logic                 thr_wr,
  input  logic [7:0]           lcr,
  input  logic [CLK_DIV_W-1:0] divisor,
  output logic                 txd,
  output logic                 thre,
  output logic                 temt
);
  import uart_8250_pkg::*;

  logic [2:0] r_state;
  logic [7:0] r_thr;
  logic [7:0] r_tsr;
  logic       r_thre;
  logic [5:0] r_lcr;
  logic [2:0] r_bitcnt;
  logic       r_par;

  logic       w_tick;
  logic       w_bit_end;
  logic       w_adv;
  logic       w_load;
  logic [5:0] w_bit_ticks;
  logic [2:0] w_last_bit;
  logic       w_par_bit;
  logic       w_line;
  logic       w_unused;

  assign w_unused    = lcr[7];
  assign w_adv       = w_tick && w_bit_end;
  assign w_load      = !r_thre && ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_adv));
  assign w_bit_ticks = (r_state == ST_STOP) ? stopTicks(r_lcr) : 6'd16;
  assign w_last_bit  = 3'd4 + {1'b0, r_lcr[1:0]};
  assign w_par_bit   = r_lcr[LCR_SP]  ? ~r_lcr[LCR_EPS] :
                       r_lcr[LCR_EPS] ? r_par : ~r_par;

  uart_8250_baudgen #(.CLK_DIV_W(CLK_DIV_W)) u_baudgen (
    .CLK_I       (CLK_I),
    .RST_I       (RST_I),
    .i_restart   (w_load),
    .i_divisor   (divisor),
    .i_bit_ticks (w_bit_ticks),
    .o_tick      (w_tick),
    .o_bit_end   (w_bit_end)
  );

  // A THR write wins over the load that empties THR on the same edge.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_state  <= ST_IDLE;
      r_thr    <= '0;
      r_tsr    <= '0;
      r_thre   <= 1'b1;
      r_lcr    <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
    end else begin
      if (thr_wr)
        r_thr <= thr_data;

      if (thr_wr)
        r_thre <= 1'b0;
      else if (w_load)
        r_thre <= 1'b1;

      if (w_load) begin
        r_state  <= ST_START;
        r_tsr    <= r_thr;
        r_lcr    <= lcr[5:0];
        r_par    <= dataParity(r_thr, lcr[1:0]);
        r_bitcnt <= '0;
      end else if (w_adv) begin
        case (r_state)
          ST_START:  r_state <= ST_DATA;
          ST_DATA: begin
            r_tsr    <= r_tsr >> 1;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == w_last_bit)
              r_state <= r_lcr[LCR_PEN] ? ST_PARITY : ST_STOP;
          end
          ST_PARITY: r_state <= ST_STOP;
          default:   r_state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    w_line = 1'b1;
    case (r_state)
      ST_START:  w_line = 1'b0;
      ST_DATA:   w_line = r_tsr[0];
      ST_PARITY: w_line = w_par_bit;
      default:   w_line = 1'b1;
    endcase
  end

  // Break acts on the live LCR so it takes effect without waiting for a bit edge.
  assign txd  = lcr[LCR_BC] ? 1'b0 : w_line;
  assign thre = r_thre;
  assign temt = r_thre && (r_state == ST_IDLE);

endmodule

// File: doc/uart_8250_tx.md
# uart_8250_tx

Transmit serialiser for the 8250-compatible UART. It sits directly downstream of the Wishbone register block `uart_8250`. It takes bytes written to THR, plus the live LCR and divisor latch values, and drives the serial TXD line. It also reports the THRE and TEMT status bits that the register block exposes in LSR and uses for the THR-empty interrupt.

## Interface
Parameters:
- `CLK_DIV_W`, default 16: width of the divisor latch (DLM:DLL).

Ports (name, direction, width, meaning):
- `CLK_I` input 1: system clock.
- `RST_I` input 1: reset, asynchronous, active-low.
- `thr_data` input 8: byte written to THR.
- `thr_wr` input 1: one-cycle THR write strobe from the register block.
- `lcr` input 8: live Line Control Register.
- `divisor` input CLK_DIV_W: live divisor latch.
- `txd` output 1: serial output; idle high.
- `thre` output 1: THR empty (LSR[5]).
- `temt` output 1: THR and shift register both empty (LSR[6]).

## Operation
Storage:
- One-entry holding register `thr`.
- One shift register `tsr`, with a per-character latched copy of lcr[5:0].

THR writes:
- `thr_wr` loads `thr` and clears `thre`.
- A write while `thre=0` overwrites `thr`. The previous byte is lost, matching the 8250.

Baud timing:
- The prescaler counts `divisor` clocks per 16x tick.
- A bit lasts 16 ticks, i.e. exactly 16·divisor clocks.
- The prescaler and tick counter restart to 0 on entry to START.
- `divisor=0`: no ticks are produced; the FSM freezes in its current state and `txd` holds its value.

FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: when `thre=0`, go to START on the next edge. On that edge: `tsr←thr`, latch lcr[5:0], set `thre=1`.
- START: `txd=0` for 16 ticks, then DATA.
- DATA: shift LSB first for N = 5 + lcr[1:0] bits. Then go to PARITY if the latched lcr[3]=1, else STOP.
- PARITY: one bit.
  - lcr[5]=1 (stick parity): bit = ~lcr[4].
  - lcr[4]=1 (even parity): bit = XOR of the N data bits.
  - Otherwise (odd parity): bit = XNOR of the N data bits.
- STOP: `txd=1`.
  - lcr[2]=0: 16 ticks.
  - lcr[2]=1 and N=5: 24 ticks.
  - lcr[2]=1 and N>5: 32 ticks.
  - At the end, go to START if `thre=0` (back-to-back, no idle gap), else IDLE.

Other rules:
- Data bits above N are ignored.
- Break: live lcr[6]=1 forces `txd=0` in every state. Serialisation continues internally and `thre`/`temt` update normally.
- `temt` = `thre` AND (state==IDLE).

## Timing
- Reset values: `txd=1`, `thre=1`, `temt=1`, state IDLE, counters 0.
- Reset is asynchronous. Asserting it mid-character drops `txd` to 1 immediately and discards `thr` and `tsr`.
- Latency: `thr_wr` sampled at edge k → `thre=0` after k. At edge k+1 → START, `txd=0`, `thre=1`.
- Simultaneous `thr_wr` and the IDLE→START (or STOP→START) load edge: `tsr` takes the old `thr`, `thr` takes the new byte, `thre=0`.
- Changes to lcr[5:0] or `divisor` mid-character:
  - lcr[5:0] changes take effect at the next character.
  - `divisor` changes take effect at the next prescaler reload.
- Character length in clocks = 16·divisor·(1 + N + P + stop ticks/16), where P = 1 if parity is enabled, else 0.

## Structure
- Package `uart_8250_pkg` holds:
  - LCR bit indices (WLS, STB, PEN, EPS, SP, BC).
  - The FSM state enum.
  - Register offsets shared with `uart_8250`.
- Sub-module `uart_8250_baudgen` contains the divisor prescaler and 16x tick counter. It has a restart input and outputs a tick and a bit-end strobe.
- Expected size: roughly 200 lines of RTL.

## Test plan
- Reset, then `divisor=1`, `lcr=0x03`, write 0x55 → `txd` low for 16 clocks, then 1,0,1,0,1,0,1,0 each 16 clocks, then high for 16 clocks. `thre` rises 1 cycle after the write; `temt` rises at 160 clocks.
- `divisor=2`, `lcr=0x1B` (8E1), write 0x07 → parity bit 1. Same with `lcr=0x0B` (8O1) → parity bit 0. Each bit is 32 clocks.
- `lcr=0x04` (5N2), write 0xFF → 5 data bits, then stop high for 24 ticks. `lcr=0x07` → stop high for 32 ticks.
- Write two bytes, the second while the first is in DATA → no idle gap between the first STOP and the second START; `temt` stays 0 throughout.
- Set `lcr[6]=1` mid-character → `txd=0` immediately; `thre`/`temt` still go to 1 on schedule.
- Assert reset in DATA → `txd=1`, `thre=1`, `temt=1` asynchronously. After release, no residual character is sent.
